photon_host_ctrl: RTL and testbench

- Bus initiator for the Photon hash accelerator; drives the photon_bus protocol from the master side.
- Accepts a 256-bit message from a client with start/done handshake, then runs the full command sequence: 8x WRITE, HASH, CHECK polling, 8x READ.
- Returns a 256-bit digest and an error flag.
- Sits between CPU-side glue (MMIO or DMA) and the photon instance, so software no longer sequences the accelerator word by word.

---
 rtl/photon_host_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_photon_host_ctrl.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/photon_host_ctrl.sv
// -----------------------------------------------------------------------------
// photon_host_ctrl
//
// Master-side sequencer for the Photon hash accelerator. A client hands over a
// 256-bit message with a start pulse; this block writes the eight message words
// into photon, issues HASH, polls CHECK until the accelerator reports
// completion (or a poll budget runs out), reads back the eight digest words and
// finishes with a one-cycle done pulse.
//
// Ports
//   clk, rst           system clock (shared with photon_bus), async active-high reset
//   start              client request, only looked at while idle
//   msg[255:0]         message, word i = msg[32*i +: 32] -> photon addr i
//   busy               high from the cycle after acceptance through the done cycle
//   done               one-cycle completion pulse
//   err                poll timeout flag, valid with done, held until next start
//   digest[255:0]      last successful digest, word i = READ of addr i
//   bus_opcode/addr/data_in   registered photon_bus command outputs
//   bus_data_out       photon read/check data (combinational in photon)
//   bus_ready          photon idle indication, not needed for sequencing
// -----------------------------------------------------------------------------
module photon_host_ctrl #(
   parameter int NWORDS        = 8,
   parameter int POLL_TIMEOUT  = 1024,
   parameter int SETTLE_CYCLES = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [32*NWORDS-1:0] msg,
   output logic                 busy,
   output logic                 done,
   output logic                 err,
   output logic [32*NWORDS-1:0] digest,
   output logic [2:0]           bus_opcode,
   output logic [2:0]           bus_addr,
   output logic [31:0]          bus_data_in,
   input  logic [31:0]          bus_data_out,
   input  logic                 bus_ready
);

   localparam int MW      = 32 * NWORDS;
   // One counter serves both the settle delay and the poll budget.
   localparam int CNT_MAX = (POLL_TIMEOUT > SETTLE_CYCLES) ? POLL_TIMEOUT : SETTLE_CYCLES;
   localparam int CW      = $clog2(CNT_MAX + 1);

   localparam logic [2:0]    LAST_IDX    = 3'(NWORDS - 1);
   localparam logic [CW-1:0] TMO_CNT     = CW'(POLL_TIMEOUT);
   localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);

   localparam logic [2:0] OP_NONE  = 3'd0;
   localparam logic [2:0] OP_READ  = 3'd1;
   localparam logic [2:0] OP_WRITE = 3'd2;
   localparam logic [2:0] OP_HASH  = 3'd3;
   localparam logic [2:0] OP_CHECK = 3'd4;

   typedef enum logic [2:0] {
      S_IDLE, S_WR, S_HASH, S_SETTLE, S_POLL, S_RD, S_FIN
   } state_t;

   state_t          state_q, state_d;
   logic [2:0]      idx_q, idx_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [CW-1:0]   cnt_inc;
   logic [MW-1:0]   msg_buf_q, msg_buf_d;
   logic [MW-1:0]   stage_q, stage_d;
   logic [MW-1:0]   digest_q, digest_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            err_q, err_d;
   logic [2:0]      opcode_q, opcode_d;
   logic [2:0]      addr_q, addr_d;
   logic [31:0]     data_in_q, data_in_d;

   // Photon's ready line is redundant with CHECK polling.
   logic unused_bus_ready;
   assign unused_bus_ready = bus_ready;

   assign cnt_inc = cnt_q + CW'(1);

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      cnt_d     = cnt_q;
      msg_buf_d = msg_buf_q;
      stage_d   = stage_q;
      digest_d  = digest_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      err_d     = err_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d   = S_WR;
               idx_d     = 3'd0;
               busy_d    = 1'b1;
               err_d     = 1'b0;
               msg_buf_d = msg;
            end
         end
         S_WR: begin
            if (idx_q == LAST_IDX) state_d = S_HASH;
            else                   idx_d   = idx_q + 3'd1;
         end
         S_HASH: begin
            state_d = S_SETTLE;
            cnt_d   = '0;
         end
         S_SETTLE: begin
            if (cnt_q == SETTLE_LAST) begin
               state_d = S_POLL;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         S_POLL: begin
            // Only bit 0 of the CHECK response carries meaning.
            if (bus_data_out[0]) begin
               state_d = S_RD;
               idx_d   = 3'd0;
            end else begin
               cnt_d = cnt_inc;
               if (cnt_inc == TMO_CNT) begin
                  state_d = S_FIN;
                  err_d   = 1'b1;
                  done_d  = 1'b1;
               end
            end
         end
         S_RD: begin
            stage_d[32*idx_q +: 32] = bus_data_out;
            if (idx_q == LAST_IDX) begin
               // Publish the digest together with done, including the last word.
               state_d  = S_FIN;
               done_d   = 1'b1;
               digest_d = stage_d;
            end else begin
               idx_d = idx_q + 3'd1;
            end
         end
         S_FIN: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
         default: state_d = S_IDLE;
      endcase

      // Bus command is a registered function of the next state and index.
      case (state_d)
         S_WR:    opcode_d = OP_WRITE;
         S_HASH:  opcode_d = OP_HASH;
         S_POLL:  opcode_d = OP_CHECK;
         S_RD:    opcode_d = OP_READ;
         default: opcode_d = OP_NONE;
      endcase

      addr_d    = addr_q;
      data_in_d = data_in_q;
      if (state_d == S_WR || state_d == S_RD) addr_d = idx_d;
      if (state_d == S_WR) data_in_d = msg_buf_d[32*idx_d +: 32];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         idx_q     <= 3'd0;
         cnt_q     <= '0;
         msg_buf_q <= '0;
         stage_q   <= '0;
         digest_q  <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         opcode_q  <= OP_NONE;
         addr_q    <= 3'd0;
         data_in_q <= 32'd0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         cnt_q     <= cnt_d;
         msg_buf_q <= msg_buf_d;
         stage_q   <= stage_d;
         digest_q  <= digest_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         err_q     <= err_d;
         opcode_q  <= opcode_d;
         addr_q    <= addr_d;
         data_in_q <= data_in_d;
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign err         = err_q;
   assign digest      = digest_q;
   assign bus_opcode  = opcode_q;
   assign bus_addr    = addr_q;
   assign bus_data_in = data_in_q;

endmodule

// File: tb/tb_photon_host_ctrl.sv
// -----------------------------------------------------------------------------
// tb_photon_host_ctrl
//
// Drives photon_host_ctrl against a behavioural photon model. Each accepted
// request pushes an expected transaction (message, poll count, error, digest)
// onto a queue; an independent monitor follows the bus cycle by cycle against
// the documented command timeline and pops/compares on every done.
// -----------------------------------------------------------------------------
module tb_photon_host_ctrl;

   localparam int T = 40;   // poll budget used for this bench
   localparam int S = 1;    // settle cycles

   localparam logic [2:0] OP_NONE  = 3'd0;
   localparam logic [2:0] OP_READ  = 3'd1;
   localparam logic [2:0] OP_WRITE = 3'd2;
   localparam logic [2:0] OP_HASH  = 3'd3;
   localparam logic [2:0] OP_CHECK = 3'd4;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [255:0] msg;
   logic         busy, done, err;
   logic [255:0] digest;
   logic [2:0]   bus_opcode, bus_addr;
   logic [31:0]  bus_data_in, bus_data_out;
   logic         bus_ready;

   always #5 clk = ~clk;

   photon_host_ctrl #(
      .NWORDS       (8),
      .POLL_TIMEOUT (T),
      .SETTLE_CYCLES(S)
   ) u_dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .msg         (msg),
      .busy        (busy),
      .done        (done),
      .err         (err),
      .digest      (digest),
      .bus_opcode  (bus_opcode),
      .bus_addr    (bus_addr),
      .bus_data_in (bus_data_in),
      .bus_data_out(bus_data_out),
      .bus_ready   (bus_ready)
   );

   typedef struct {
      logic [255:0] m;
      logic         ok;
      int           p;
      logic [255:0] dig;
      int           id;
   } exp_t;

   exp_t         exp_q[$];
   int           lat_q[$];
   int           checks = 0;
   int           errors = 0;
   logic [255:0] last_digest = '0;
   int           txn_id = 0;

   // Accelerator "hash": word i = message word i xor B5A5_0000.
   function automatic logic [255:0] photon_hash(input logic [255:0] m);
      logic [255:0] r;
      for (int i = 0; i < 8; i++) r[32*i +: 32] = m[32*i +: 32] ^ 32'hB5A5_0000;
      return r;
   endfunction

   function automatic logic [255:0] rand_msg();
      logic [255:0] r;
      for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
      return r;
   endfunction

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, expv);
      end
   endtask

   // ---------------- photon model ----------------
   // Ready is reported on the lat-th CHECK cycle after HASH.
   logic [255:0] ph_mem    = '0;
   logic [255:0] ph_hash;
   int           ph_checks = 0;
   int           ph_lat    = 1;
   logic [31:0]  noise     = '0;

   assign ph_hash   = photon_hash(ph_mem);
   assign bus_ready = (ph_checks + 1 >= ph_lat);

   always @(posedge clk) begin
      noise <= $urandom;
      if (bus_opcode == OP_WRITE) ph_mem[32*bus_addr +: 32] <= bus_data_in;
      if (bus_opcode == OP_HASH) begin
         ph_checks <= 0;
         if (lat_q.size() > 0) ph_lat <= lat_q.pop_front();
      end else if (bus_opcode == OP_CHECK) begin
         ph_checks <= ph_checks + 1;
      end
   end

   always_comb begin
      bus_data_out = noise;
      if (bus_opcode == OP_READ)       bus_data_out = ph_hash[32*bus_addr +: 32];
      else if (bus_opcode == OP_CHECK) bus_data_out = {noise[31:1], (ph_checks + 1 >= ph_lat)};
   end

   // ---------------- monitor ----------------
   logic       mon_active = 1'b0;
   logic       busy_prev  = 1'b0;
   exp_t       cur;
   int         cyc = 0;
   int         len = 0;

   initial begin
      logic [2:0]  e_op;
      logic [2:0]  e_addr, a_addr;
      logic [31:0] e_data, a_data;
      logic        use_addr, use_data;
      forever begin
         @(negedge clk);
         if (rst) begin
            mon_active = 1'b0;
            busy_prev  = 1'b0;
         end else begin
            if (busy && !busy_prev) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_start: busy rose with no request queued");
               end else begin
                  cur        = exp_q[0];
                  mon_active = 1'b1;
                  cyc        = 1;
                  len        = 8 + 1 + S + cur.p + (cur.ok ? 8 : 0) + 1;
               end
            end
            if (mon_active) begin
               e_op = OP_NONE; e_addr = 3'd0; e_data = 32'd0;
               use_addr = 1'b0; use_data = 1'b0;
               if (cyc <= 8) begin
                  e_op = OP_WRITE; use_addr = 1'b1; use_data = 1'b1;
                  e_addr = 3'(cyc - 1);
                  e_data = cur.m[32*(cyc-1) +: 32];
               end else if (cyc == 9) begin
                  e_op = OP_HASH;
               end else if (cyc <= 9 + S) begin
                  e_op = OP_NONE;
               end else if (cyc <= 9 + S + cur.p) begin
                  e_op = OP_CHECK;
               end else if (cur.ok && cyc <= 17 + S + cur.p) begin
                  e_op = OP_READ; use_addr = 1'b1;
                  e_addr = 3'(cyc - (10 + S + cur.p));
               end
               a_addr = use_addr ? bus_addr : 3'd0;
               a_data = use_data ? bus_data_in : 32'd0;
               chk($sformatf("bus_t%0d_cyc%0d", cur.id, cyc),
                   {bus_opcode, a_addr, a_data}, {e_op, e_addr, e_data});
               chk($sformatf("done_t%0d_cyc%0d", cur.id, cyc), done, (cyc == len));
               chk($sformatf("busy_t%0d_cyc%0d", cur.id, cyc), busy, 1'b1);
               if (cyc < len) chk($sformatf("err_t%0d_cyc%0d", cur.id, cyc), err, 1'b0);
               if (cyc == len) begin
                  chk($sformatf("err_t%0d", cur.id), err, !cur.ok);
                  chk($sformatf("digest_t%0d", cur.id), digest, cur.dig);
                  $display("txn %0d: polls=%0d err=%0b digest=%h", cur.id, cur.p, err, digest);
                  void'(exp_q.pop_front());
                  mon_active = 1'b0;
               end
               cyc++;
            end else begin
               chk("done_idle", done, 1'b0);
               chk("busy_idle", busy, 1'b0);
               chk("opcode_idle", bus_opcode, OP_NONE);
            end
            busy_prev = busy;
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic push_exp(input logic [255:0] m, input int lat);
      exp_t e;
      e.m  = m;
      e.ok = (lat <= T);
      e.p  = e.ok ? lat : T;
      if (e.ok) last_digest = photon_hash(m);
      e.dig = last_digest;
      e.id  = txn_id++;
      lat_q.push_back(lat);
      exp_q.push_back(e);
   endtask

   task automatic wait_idle();
      int n;
      for (n = 0; n < 3000; n++) begin
         @(negedge clk); #1;
         if (!busy && exp_q.size() == 0) break;
      end
      if (n == 3000) begin
         checks++;
         errors++;
         $display("FAIL wait_idle: still busy=%0b pending=%0d, required idle", busy, exp_q.size());
      end
   endtask

   task automatic wait_op(input logic [2:0] op, input int addr);
      int n;
      for (n = 0; n < 500; n++) begin
         @(negedge clk); #1;
         if (bus_opcode == op && (addr < 0 || int'(bus_addr) == addr)) break;
      end
      if (n == 500) begin
         checks++;
         errors++;
         $display("FAIL wait_op: opcode %0d addr %0d never seen, last opcode %0d", op, addr, bus_opcode);
      end
   endtask

   task automatic issue(input logic [255:0] m, input int lat);
      wait_idle();
      msg   = m;
      push_exp(m, lat);
      start = 1'b1;
      @(negedge clk); #1;
      start = 1'b0;
      msg   = rand_msg();   // later changes must not affect the transaction
   endtask

   task automatic check_reset_values(input string tag);
      chk({tag, "_busy"},   busy, 1'b0);
      chk({tag, "_done"},   done, 1'b0);
      chk({tag, "_err"},    err, 1'b0);
      chk({tag, "_digest"}, digest, 256'd0);
      chk({tag, "_opcode"}, bus_opcode, OP_NONE);
      chk({tag, "_addr"},   bus_addr, 3'd0);
      chk({tag, "_data"},   bus_data_in, 32'd0);
   endtask

   initial begin
      logic [255:0] m, ma, mb;
      int           n;
      rst   = 1'b0;
      start = 1'b0;
      msg   = '0;
      #1 rst = 1'b1;
      #1 check_reset_values("reset");
      repeat (3) @(negedge clk);
      #1 rst = 1'b0;
      @(posedge clk); #1;
      chk("post_reset_opcode", bus_opcode, OP_NONE);

      // Directed: known message, 26 polls.
      for (int i = 0; i < 8; i++) m[32*i +: 32] = 32'h1000_0000 + i;
      issue(m, 26);

      // Timeout: ready never asserted; digest must stay.
      issue(rand_msg(), 1000);

      // Extra start pulses during WR and POLL are ignored.
      issue(rand_msg(), 12);
      start = 1'b1;
      @(negedge clk); #1;
      start = 1'b0;
      wait_op(OP_CHECK, -1);
      start = 1'b1;
      @(negedge clk); #1;
      start = 1'b0;

      // Asynchronous reset in the middle of the read-back.
      issue(rand_msg(), 5);
      wait_op(OP_READ, 3);
      #1 rst = 1'b1;
      exp_q.delete();
      lat_q.delete();
      last_digest = '0;
      #1 check_reset_values("midrst");
      repeat (2) @(negedge clk);
      #1 rst = 1'b0;
      @(posedge clk); #1;
      chk("midrst_release_opcode", bus_opcode, OP_NONE);
      chk("midrst_release_busy", busy, 1'b0);

      // Clean run after reset.
      issue(rand_msg(), 3);

      // Back-to-back with start held high.
      wait_idle();
      ma    = rand_msg();
      mb    = rand_msg();
      msg   = ma;
      push_exp(ma, 7);
      start = 1'b1;
      for (n = 0; n < 10 && !busy; n++) begin @(negedge clk); #1; end
      msg = mb;
      push_exp(mb, 2);
      for (n = 0; n < 200 && exp_q.size() > 1; n++) begin @(negedge clk); #1; end
      n = 0;
      do begin @(negedge clk); #1; n++; end while (!busy && n < 10);
      chk("b2b_restart_gap", n, 2);
      start = 1'b0;

      // Randomised traffic, including timeouts and stray start pulses.
      for (int k = 0; k < 8; k++) begin
         repeat ($urandom_range(0, 3)) @(negedge clk);
         issue(rand_msg(), int'($urandom_range(1, T + 6)));
         if ($urandom_range(0, 1) == 1) begin
            repeat ($urandom_range(1, 30)) @(negedge clk);
            #1;
            if (busy) begin
               start = 1'b1;
               @(negedge clk); #1;
               start = 1'b0;
            end
         end
      end
      wait_idle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      errors++;
      $display("FAIL watchdog: simulation did not complete");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
